// File: rtl/time2stamp_if.sv
// Request/result bundle for the BCD calendar-to-Unix-seconds converter.
// The requester owns start and the BCD fields; the converter owns busy/done/err/stamp.
interface time2stamp_if;
  logic        start;
  logic [15:0] year_bcd;
  logic [7:0]  month_bcd;
  logic [7:0]  day_bcd;
  logic [7:0]  hour_bcd;
  logic [7:0]  minute_bcd;
  logic [7:0]  second_bcd;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] stamp;

  modport master (
    output start, year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd,
    input  busy, done, err, stamp
  );

  modport slave (
    input  start, year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd,
    output busy, done, err, stamp
  );
endinterface

// File: rtl/time2stamp.sv
// Converts a BCD calendar date/time (1970..2099) into Unix seconds by iterating
// over whole years and months, then combining with the time of day.
module time2stamp (
  input  logic          clk,
  input  logic          rst_n,
  time2stamp_if.slave   bus,
  output logic [2:0]    o_dbg_state
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_YEARS   = 3'd2;
  localparam logic [2:0] S_MONTHS  = 3'd3;
  localparam logic [2:0] S_COMBINE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic [2:0]  r_state;
  logic [15:0] r_y_bcd;
  logic [7:0]  r_mo_bcd, r_d_bcd, r_h_bcd, r_mi_bcd, r_s_bcd;
  logic [11:0] r_year, r_iter;
  logic [3:0]  r_month, r_mon_iter;
  logic [4:0]  r_day, r_hour;
  logic [5:0]  r_min, r_sec;
  logic [15:0] r_acc;
  logic        r_done, r_err;
  logic [63:0] r_stamp;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  logic [55:0] w_all_bcd;
  logic        w_nib_ok;
  logic [13:0] w_year_bin;
  logic [6:0]  w_mo_bin, w_d_bin, w_h_bin, w_mi_bin, w_s_bin;
  logic [4:0]  w_dim;
  logic        w_valid;
  logic [8:0]  w_year_len;
  logic [4:0]  w_mon_len;
  logic [16:0] w_days;
  logic [39:0] w_secs;

  assign w_all_bcd = {r_y_bcd, r_mo_bcd, r_d_bcd, r_h_bcd, r_mi_bcd, r_s_bcd};

  always_comb begin
    w_nib_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (w_all_bcd[i*4 +: 4] > 4'd9) w_nib_ok = 1'b0;
    end
  end

  assign w_year_bin = 14'(r_y_bcd[15:12]) * 14'd1000 + 14'(r_y_bcd[11:8]) * 14'd100
                    + 14'(r_y_bcd[7:4]) * 14'd10 + 14'(r_y_bcd[3:0]);
  assign w_mo_bin = bcd2bin(r_mo_bcd);
  assign w_d_bin  = bcd2bin(r_d_bcd);
  assign w_h_bin  = bcd2bin(r_h_bcd);
  assign w_mi_bin = bcd2bin(r_mi_bcd);
  assign w_s_bin  = bcd2bin(r_s_bcd);
  assign w_dim    = month_len(w_mo_bin[3:0], w_year_bin[1:0] == 2'b00);

  // Day range is only trusted once month is known to be 1..12.
  assign w_valid = w_nib_ok
                && (w_year_bin >= 14'd1970) && (w_year_bin <= 14'd2099)
                && (w_mo_bin >= 7'd1) && (w_mo_bin <= 7'd12)
                && (w_d_bin >= 7'd1) && (w_d_bin <= 7'(w_dim))
                && (w_h_bin <= 7'd23) && (w_mi_bin <= 7'd59) && (w_s_bin <= 7'd59);

  // Divisible-by-4 is the exact leap rule across 1970..2099.
  assign w_year_len = (r_iter[1:0] == 2'b00) ? 9'd366 : 9'd365;
  assign w_mon_len  = month_len(r_mon_iter, r_year[1:0] == 2'b00);
  assign w_days     = 17'(r_acc) + 17'(r_day) - 17'd1;
  assign w_secs     = 40'(w_days) * 40'd86400 + 40'(r_hour) * 40'd3600
                    + 40'(r_min) * 40'd60 + 40'(r_sec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_y_bcd <= '0; r_mo_bcd <= '0; r_d_bcd <= '0;
      r_h_bcd <= '0; r_mi_bcd <= '0; r_s_bcd <= '0;
      r_year <= '0; r_iter <= '0; r_month <= '0; r_mon_iter <= '0;
      r_day <= '0; r_hour <= '0; r_min <= '0; r_sec <= '0;
      r_acc <= '0; r_done <= 1'b0; r_err <= 1'b0; r_stamp <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !r_done) begin
            r_y_bcd  <= bus.year_bcd;   r_mo_bcd <= bus.month_bcd;
            r_d_bcd  <= bus.day_bcd;    r_h_bcd  <= bus.hour_bcd;
            r_mi_bcd <= bus.minute_bcd; r_s_bcd  <= bus.second_bcd;
            r_err    <= 1'b0;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_valid) begin
            r_year  <= w_year_bin[11:0]; r_month <= w_mo_bin[3:0];
            r_day   <= w_d_bin[4:0];     r_hour  <= w_h_bin[4:0];
            r_min   <= w_mi_bin[5:0];    r_sec   <= w_s_bin[5:0];
            r_acc   <= '0;
            r_iter  <= 12'd1970;
            r_state <= S_YEARS;
          end else begin
            r_state <= S_ERR;
          end
        end
        S_YEARS: begin
          if (r_iter < r_year) begin
            r_acc  <= r_acc + 16'(w_year_len);
            r_iter <= r_iter + 12'd1;
          end else begin
            r_mon_iter <= 4'd1;
            r_state    <= S_MONTHS;
          end
        end
        S_MONTHS: begin
          if (r_mon_iter < r_month) begin
            r_acc      <= r_acc + 16'(w_mon_len);
            r_mon_iter <= r_mon_iter + 4'd1;
          end else begin
            r_state <= S_COMBINE;
          end
        end
        S_COMBINE: begin
          r_stamp <= {24'd0, w_secs};
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR: begin
          r_done  <= 1'b1;
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake: start is sampled only when busy is low; busy covers every
  // non-IDLE state plus the done pulse cycle, so no request is ever queued.
  assign bus.busy  = (r_state != S_IDLE) || r_done;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.stamp = r_stamp;
  assign o_dbg_state = r_state;
endmodule
